// File: rtl/reg_file_wb.sv
// Writeback register file: two combinational read ports, one write port, x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding, a live x10 tap and a committed-write counter.
module reg_file_wb #(
   parameter int W      = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] AD1,
   input  logic [AW-1:0] AD2,
   input  logic [AW-1:0] AD3,
   input  logic          WE3,
   input  logic [W-1:0]  WD3,
   output logic [W-1:0]  RD1,
   output logic [W-1:0]  RD2,
   output logic [W-1:0]  a0,
   output logic [31:0]   WrCount
);

   localparam int N = 2 ** AW;

   logic [W-1:0] r_regs [N];
   logic [31:0]  r_wr_count;
   logic         w_commit;
   logic         w_fwd1;
   logic         w_fwd2;

   // Reset outranks a concurrent write, and x0 is never a write target.
   assign w_commit = WE3 && (AD3 != '0) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            r_regs[i] <= '0;
         end
         r_wr_count <= '0;
      end else if (w_commit) begin
         r_regs[AD3] <= WD3;
         r_wr_count  <= r_wr_count + 32'd1;
      end
   end

   // Forwarding only when the write will actually commit on this edge.
   assign w_fwd1 = (BYPASS != 0) && w_commit && (AD1 == AD3);
   assign w_fwd2 = (BYPASS != 0) && w_commit && (AD2 == AD3);

   always_comb begin
      RD1 = r_regs[AD1];
      if (AD1 == '0) begin
         RD1 = '0;
      end else if (w_fwd1) begin
         RD1 = WD3;
      end
   end

   always_comb begin
      RD2 = r_regs[AD2];
      if (AD2 == '0) begin
         RD2 = '0;
      end else if (w_fwd2) begin
         RD2 = WD3;
      end
   end

   generate
      if (N > 10) begin : g_a0
         assign a0 = r_regs[10];
      end else begin : g_no_a0
         assign a0 = '0;
      end
   endgenerate

   assign WrCount = r_wr_count;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed and randomized checks of reg_file_wb against an array-based model,
// with one forwarding and one non-forwarding instance driven from the same inputs.
module tb_reg_file_wb;

   logic        clk;
   logic        rst;
   logic [4:0]  AD1, AD2, AD3;
   logic        WE3;
   logic [31:0] WD3;
   logic [31:0] rd1_b, rd2_b, a0_b, cnt_b;
   logic [31:0] rd1_nb, rd2_nb, a0_nb, cnt_nb;

   int vectors;
   int miscompares;

   logic [31:0] model_regs [32];
   logic [31:0] model_count;

   reg_file_wb #(.W(32), .AW(5), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .WD3(WD3),
      .RD1(rd1_b), .RD2(rd2_b), .a0(a0_b), .WrCount(cnt_b)
   );

   reg_file_wb #(.W(32), .AW(5), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .WD3(WD3),
      .RD1(rd1_nb), .RD2(rd2_nb), .a0(a0_nb), .WrCount(cnt_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected read data: x0 is zero, a committing write is visible early only with forwarding.
   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit fwd);
      if (a == 5'd0) return 32'd0;
      if (fwd && !rst && WE3 && AD3 != 5'd0 && a == AD3) return WD3;
      return model_regs[a];
   endfunction

   task automatic step(input bit r, input bit we, input logic [4:0] ad3, input logic [31:0] wd3,
                       input logic [4:0] ad1, input logic [4:0] ad2);
      @(negedge clk);
      rst = r; WE3 = we; AD3 = ad3; WD3 = wd3; AD1 = ad1; AD2 = ad2;
      #1;
      check("rd1_bypass", rd1_b, exp_rd(ad1, 1'b1));
      check("rd2_bypass", rd2_b, exp_rd(ad2, 1'b1));
      check("rd1_nobypass", rd1_nb, exp_rd(ad1, 1'b0));
      check("rd2_nobypass", rd2_nb, exp_rd(ad2, 1'b0));
      check("a0", a0_b, model_regs[10]);
      check("a0_nobypass", a0_nb, model_regs[10]);
      check("wrcount", cnt_b, model_count);
      check("wrcount_nobypass", cnt_nb, model_count);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
         model_count = 32'd0;
      end else if (we && ad3 != 5'd0) begin
         model_regs[ad3] = wd3;
         model_count = model_count + 32'd1;
      end
   endtask

   initial begin
      logic [31:0] v;
      vectors = 0;
      miscompares = 0;
      rst = 1'b1; WE3 = 1'b0; AD1 = '0; AD2 = '0; AD3 = '0; WD3 = '0;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 32'd0;
      repeat (2) @(posedge clk);

      // Held reset with a write pending: write ignored, reads show cleared state.
      step(1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
      // All addresses read zero on both ports after reset.
      for (int a = 0; a < 32; a++) step(1'b0, 1'b0, 5'd0, 32'd0, a[4:0], 5'(31 - a));

      // Basic write then read back.
      step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd1);
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
      // Write to x0 is discarded.
      step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
      // Same-cycle forwarding on both ports, then registered value.
      step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
      // Rewriting an identical value still counts.
      step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd3);
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
      // a0 tap, then reset racing a write to x10.
      step(1'b0, 1'b1, 5'd10, 32'h0000002A, 5'd10, 5'd10);
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd5);
      step(1'b1, 1'b1, 5'd10, 32'h000000FF, 5'd10, 5'd10);
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd5);
      // First write after reset release commits at once.
      step(1'b0, 1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30);
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd31);

      // Randomized traffic with occasional mid-run resets.
      for (int n = 0; n < 300; n++) begin
         v = $urandom;
         step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 31)), v,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end

      // Counter wrap: preload both counters to all-ones, then one write.
      #2;
      force dut.r_wr_count = 32'hFFFFFFFF;
      force dut_nb.r_wr_count = 32'hFFFFFFFF;
      #1;
      release dut.r_wr_count;
      release dut_nb.r_wr_count;
      model_count = 32'hFFFFFFFF;
      step(1'b0, 1'b1, 5'd12, 32'h00000BAD, 5'd12, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
